// File: rtl/braun_pkg.sv
// Shared helpers for the pipelined Braun multiplier: stage count and the HA/FA cell.
package braun_pkg;

   typedef struct packed {
      logic c;
      logic s;
   } fa_t;

   function automatic int stage_cnt(input int width, input int rps);
      return (width + rps - 1) / rps;
   endfunction

   function automatic fa_t fa(input logic x, input logic y, input logic z);
      fa_t r;
      r.s = x ^ y ^ z;
      r.c = (x & y) | (x & z) | (y & z);
      return r;
   endfunction

endpackage

// File: rtl/braun_row.sv
// One combinational Braun carry-save row; sgn applies Baugh-Wooley inversion of the
// MSB cross partial products for this row.
module braun_row
   import braun_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int ROW   = 0
) (
   input  logic [WIDTH-1:0] a,
   input  logic             bj,
   input  logic [WIDTH-1:1] s_hi,
   input  logic [WIDTH-1:0] c_in,
   input  logic             sgn,
   output logic [WIDTH-1:0] s_out,
   output logic [WIDTH-1:0] c_out
);

   logic [WIDTH-1:0] sx;

   // previous row's sum shifts down one column as its LSB retires
   assign sx = {1'b0, s_hi};

   for (genvar i = 0; i < WIDTH; i++) begin : g_col
      localparam logic INV = (ROW == WIDTH-1) ? (i != WIDTH-1) : (i == WIDTH-1);
      logic pp;
      assign pp = (a[i] & bj) ^ (sgn & INV);
      assign {c_out[i], s_out[i]} = fa(pp, sx[i], c_in[i]);
   end

endmodule

// File: rtl/braun_mult_pipe.sv
// Pipelined Braun array multiplier with valid/ready on both sides.
// Define BRAUN_SIGNED_EN to enable per-operation two's-complement mode (in_signed).
module braun_mult_pipe
   import braun_pkg::*;
#(
   parameter int WIDTH          = 8,
   parameter int ROWS_PER_STAGE = 2,
   parameter int TAG_W          = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   input  logic [TAG_W-1:0]   in_tag,
   input  logic               in_signed,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_p,
   output logic [TAG_W-1:0]   out_tag
);

   localparam int NSTG = stage_cnt(WIDTH, ROWS_PER_STAGE);

   typedef struct packed {
      logic [TAG_W-1:0]   tag;
      logic [WIDTH-1:0]   a;
      logic [WIDTH-1:0]   b;
      logic [WIDTH-1:1]   s;
      logic [WIDTH-1:0]   c;
      logic [2*WIDTH-1:0] lo;
`ifdef BRAUN_SIGNED_EN
      logic               sgn;
`endif
   } stg_t;

   // p[0] is the operand register; p[s+1] holds the result of stage s rows
   stg_t             p [NSTG+1];
   stg_t             in0;
   logic [NSTG:0]    vld_pipe;
   logic [WIDTH-1:0] lsb;
   logic             en;

   assign en        = !vld_pipe[NSTG] || out_ready;
   assign in_ready  = en;
   assign out_valid = vld_pipe[NSTG];
   assign out_p     = p[NSTG].lo;
   assign out_tag   = p[NSTG].tag;

   always_comb begin
      in0     = '0;
      in0.tag = in_tag;
      in0.a   = in_a;
      in0.b   = in_b;
`ifdef BRAUN_SIGNED_EN
      in0.sgn = in_signed;
`endif
   end

`ifndef BRAUN_SIGNED_EN
   logic unused_sgn;
   assign unused_sgn = in_signed;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_pipe <= '0;
         p[0]     <= '0;
      end else if (en) begin
         vld_pipe <= {vld_pipe[NSTG-1:0], in_valid};
         p[0]     <= in0;
      end
   end

   for (genvar r = 0; r < WIDTH; r++) begin : g_row
      localparam int S = r / ROWS_PER_STAGE;
      logic [WIDTH-1:1] si;
      logic [WIDTH-1:0] ci, so, co;
      logic             sg;

      if (r % ROWS_PER_STAGE == 0) begin : g_head
         assign si = p[S].s;
         assign ci = p[S].c;
      end else begin : g_chain
         assign si = g_row[r-1].so[WIDTH-1:1];
         assign ci = g_row[r-1].co;
      end

`ifdef BRAUN_SIGNED_EN
      assign sg = p[S].sgn;
`else
      assign sg = 1'b0;
`endif

      braun_row #(.WIDTH(WIDTH), .ROW(r)) u_row (
         .a     (p[S].a),
         .bj    (p[S].b[r]),
         .s_hi  (si),
         .c_in  (ci),
         .sgn   (sg),
         .s_out (so),
         .c_out (co)
      );

      assign lsb[r] = so[0];
   end

   for (genvar s = 0; s < NSTG; s++) begin : g_stg
      localparam int R0 = s * ROWS_PER_STAGE;
      localparam int R1 = ((s+1) * ROWS_PER_STAGE > WIDTH) ? WIDTH-1 : (s+1) * ROWS_PER_STAGE - 1;
      stg_t             nx;
      logic [WIDTH-1:0] sx, hi;
      logic             cy, sg;

`ifdef BRAUN_SIGNED_EN
      assign sg = p[s].sgn;
`else
      assign sg = 1'b0;
`endif

      always_comb begin
         nx            = p[s];
         nx.lo[R1:R0]  = lsb[R1:R0];
         nx.s          = g_row[R1].so[WIDTH-1:1];
         nx.c          = g_row[R1].co;
         sx            = {1'b0, nx.s};
         hi            = '0;
         cy            = sg;
         // ripple merge; signed mode adds 2^WIDTH via carry-in and 2^(2W-1) via MSB flip
         if (s == NSTG-1) begin
            for (int i = 0; i < WIDTH; i++)
               {cy, hi[i]} = fa(sx[i], nx.c[i], cy);
            nx.lo[2*WIDTH-1:WIDTH] = hi ^ {sg, {(WIDTH-1){1'b0}}};
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst)
            p[s+1] <= '0;
         else if (en)
            p[s+1] <= nx;
      end
   end

endmodule

// File: tb/tb_braun_mult_pipe.sv
// Bench for braun_mult_pipe: directed table, latency, stall/backpressure, reset, and a
// WIDTH=4/RPS=3 exhaustive sweep. Signed vectors are added when BRAUN_SIGNED_EN is set.
module tb_braun_mult_pipe;

   localparam int NSTG = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, in_signed, out_valid, out_ready;
   logic [7:0]  in_a, in_b;
   logic [3:0]  in_tag, out_tag;
   logic [15:0] out_p;

   logic        s_in_valid, s_in_ready, s_sgn, s_out_valid, s_out_ready;
   logic [3:0]  s_a, s_b, s_tag, s_out_tag;
   logic [7:0]  s_p;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [3:0]  tag;
      logic        sgn;
      logic [15:0] p;
   } vec_t;

   typedef struct {
      logic [15:0] p;
      logic [3:0]  t;
   } exp_t;

   vec_t tbl[$];
   exp_t q[$];

   always #5 clk = ~clk;

   braun_mult_pipe #(.WIDTH(8), .ROWS_PER_STAGE(2), .TAG_W(4)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .in_signed(in_signed),
      .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p), .out_tag(out_tag)
   );

   braun_mult_pipe #(.WIDTH(4), .ROWS_PER_STAGE(3), .TAG_W(4)) u_dut4 (
      .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
      .in_a(s_a), .in_b(s_b), .in_tag(s_tag), .in_signed(s_sgn),
      .out_valid(s_out_valid), .out_ready(s_out_ready), .out_p(s_p), .out_tag(s_out_tag)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic [7:0] a, input logic [7:0] b, input logic [3:0] t,
                      input logic sg, input logic [15:0] p);
      vec_t v;
      v.a = a; v.b = b; v.tag = t; v.sgn = sg; v.p = p;
      tbl.push_back(v);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   sent, got, cyc, idx;
      bit   in_fire, stall_prev;
      logic [15:0] held_p;
      logic [3:0]  held_t;
      logic [7:0]  ev;
      exp_t e;

      rst = 1'b1; in_valid = 0; in_a = 0; in_b = 0; in_tag = 0; in_signed = 0; out_ready = 1;
      s_in_valid = 0; s_a = 0; s_b = 0; s_tag = 0; s_sgn = 0; s_out_ready = 1;

      // reset state
      #12;
      chk("rst_vld", out_valid, 0);
      chk("rst_p", out_p, 0);
      chk("rst_tag", out_tag, 0);
      chk("rst_rdy", in_ready, 1);
      tick();
      rst = 1'b0;
      #1;
      chk("post_rst_rdy", in_ready, 1);

      // single op, latency NSTG
      in_valid = 1; in_a = 8'd13; in_b = 8'd11; in_tag = 4'd5;
      tick();
      in_valid = 0;
      chk("lat_v0", out_valid, 0);
      for (int i = 1; i <= 5; i++) begin
         tick();
         chk("lat_vld", out_valid, (i == NSTG) ? 1 : 0);
         if (i == NSTG) begin
            chk("lat_p", out_p, 16'd143);
            chk("lat_tag", out_tag, 4'd5);
         end
      end

      // directed table, streamed back to back
      add(8'd13,  8'd11,  4'd1, 0, 16'd143);
      add(8'd255, 8'd255, 4'd2, 0, 16'hFE01);
      add(8'd0,   8'd77,  4'd3, 0, 16'd0);
      add(8'd1,   8'd200, 4'd4, 0, 16'd200);
      add(8'd128, 8'd2,   4'd5, 0, 16'd256);
      add(8'd15,  8'd17,  4'd6, 0, 16'd255);
      add(8'd100, 8'd100, 4'd7, 0, 16'd10000);
      add(8'd200, 8'd3,   4'd8, 0, 16'd600);
      add(8'd170, 8'd85,  4'd9, 0, 16'd14450);
      add(8'd37,  8'd59,  4'd10, 0, 16'd2183);
      add(8'd255, 8'd1,   4'd11, 0, 16'd255);
      add(8'd77,  8'd0,   4'd12, 0, 16'd0);
`ifdef BRAUN_SIGNED_EN
      add(8'hFD, 8'd7,   4'd13, 1, 16'hFFEB);
      add(8'hFD, 8'd7,   4'd14, 0, 16'h06EB);
      add(8'h80, 8'h80,  4'd15, 1, 16'h4000);
      add(8'hFF, 8'hFF,  4'd0,  1, 16'h0001);
      add(8'h80, 8'h7F,  4'd1,  1, 16'hC080);
      add(8'h7F, 8'h7F,  4'd2,  1, 16'h3F01);
      add(8'hFF, 8'hFF,  4'd3,  0, 16'hFE01);
`endif
      out_ready = 1;
      for (int i = 0; i < tbl.size() + NSTG + 2; i++) begin
         if (i < tbl.size()) begin
            in_valid = 1; in_a = tbl[i].a; in_b = tbl[i].b; in_tag = tbl[i].tag; in_signed = tbl[i].sgn;
         end else begin
            in_valid = 0; in_signed = 0;
         end
         chk("tbl_rdy", in_ready, 1);
         tick();
         chk("tbl_vld", out_valid, (i >= NSTG && i - NSTG < tbl.size()) ? 1 : 0);
         if (i >= NSTG && i - NSTG < tbl.size()) begin
            chk($sformatf("tbl_p[%0d]", i - NSTG), out_p, tbl[i-NSTG].p);
            chk($sformatf("tbl_tag[%0d]", i - NSTG), out_tag, tbl[i-NSTG].tag);
         end
      end

      // random stream with pseudo-random backpressure
      in_valid = 0; in_fire = 0; stall_prev = 0; sent = 0; got = 0; cyc = 0;
      held_p = 0; held_t = 0;
      while ((sent < 40 || got < 40) && cyc < 3000) begin
         if (!in_valid || in_fire) begin
            if (sent < 40) begin
               in_valid = 1; in_a = 8'($urandom); in_b = 8'($urandom); in_tag = 4'($urandom);
            end else
               in_valid = 0;
         end
         out_ready = ($urandom_range(2) != 0);
         @(negedge clk);
         chk("st_rdy", in_ready, (!out_valid || out_ready) ? 1 : 0);
         if (stall_prev) begin
            chk("hold_v", out_valid, 1);
            chk("hold_p", out_p, held_p);
            chk("hold_t", out_tag, held_t);
         end
         in_fire = in_valid && in_ready;
         if (in_fire) begin
            e.p = {8'h00, in_a} * {8'h00, in_b};
            e.t = in_tag;
            q.push_back(e);
            sent++;
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               total++; bad++;
               $display("FAIL st_spurious: got product %0h want none", out_p);
            end else begin
               e = q.pop_front();
               chk("st_p", out_p, e.p);
               chk("st_t", out_tag, e.t);
               got++;
            end
         end
         stall_prev = out_valid && !out_ready;
         held_p = out_p;
         held_t = out_tag;
         tick();
         cyc++;
      end
      chk("st_count", got, 40);
      chk("st_inflight", q.size(), 0);
      in_valid = 0; out_ready = 1;
      repeat (6) tick();

      // reset with ops in flight, first one stalled at the output
      out_ready = 0;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1; in_a = 8'(k + 3); in_b = 8'd9; in_tag = 4'(k + 1);
         tick();
      end
      in_valid = 0;
      tick();
      tick();
      chk("pre_rst_vld", out_valid, 1);
      chk("pre_rst_p", out_p, 16'd27);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_vld", out_valid, 0);
      chk("async_rst_p", out_p, 0);
      chk("async_rst_tag", out_tag, 0);
      tick();
      rst = 1'b0;
      out_ready = 1;
      for (int k = 0; k < 8; k++) begin
         tick();
         chk("post_rst_quiet", out_valid, 0);
      end

      // WIDTH=4, RPS=3: two stages, exhaustive stream
      chk("w4_rdy", s_in_ready, 1);
      for (int i = 0; i < 256 + 4; i++) begin
         ev = 8'(i);
         s_in_valid = (i < 256);
         s_a = ev[7:4]; s_b = ev[3:0]; s_tag = ev[3:0];
         tick();
         chk("w4_vld", s_out_valid, (i >= 2 && i - 2 < 256) ? 1 : 0);
         if (i >= 2 && i - 2 < 256) begin
            idx = i - 2;
            chk($sformatf("w4_p[%0d]", idx), s_p, (idx >> 4) * (idx & 15));
            chk("w4_tag", s_out_tag, idx & 15);
         end
      end
      s_in_valid = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
